// File: rtl/multicycle_control_unit_pkg.sv
// mc_ctrl_pkg: shared types and constants for the multicycle RV32I control unit.
//   state_t  - FSM state encoding (4 bits)
//   alu_op_t - coarse ALU request from the FSM to the ALU decoder
//   OP_*     - major opcodes, ALU_* - alu_control encodings, *_SEL - mux selects
//   imm_of() - immediate format implied by an opcode
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, TRAP
  } state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// mc_ctrl_if: control unit <-> multicycle datapath bundle.
//   master: control unit (decode fields, ALU flags, mem_ready in; strobes/selects out)
//   slave : datapath side (mirror image)
interface mc_ctrl_if #(parameter int ALUCTRL_W = 4) ();
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 zero, negative, carry, overflow;
  logic                 mem_ready;
  logic                 mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
  logic [1:0]           result_src, alu_src_a, alu_src_b;
  logic [2:0]           imm_src;
  logic [ALUCTRL_W-1:0] alu_control;

  modport master (
    input  op, funct3, funct7b5, zero, negative, carry, overflow, mem_ready,
    output mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control
  );
  modport slave (
    output op, funct3, funct7b5, zero, negative, carry, overflow, mem_ready,
    input  mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control
  );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// mc_alu_decoder: combinational ALU operation decoder.
//   i_alu_op        - add / sub / decode-from-funct request
//   i_funct3, i_funct7b5, i_op5 - instruction fields
//   o_alu_control   - low ALUCTRL_W bits of the 4-bit ALU encoding
//   o_illegal       - funct fields name an op not encodable at this width
//                     (only meaningful for R/I-type instructions)
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  alu_op_t              i_alu_op,
  input  logic [2:0]           i_funct3,
  input  logic                 i_funct7b5,
  input  logic                 i_op5,
  output logic [ALUCTRL_W-1:0] o_alu_control,
  output logic                 o_illegal
);
  logic [3:0] w_full;

  always_comb begin
    w_full = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: w_full = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  w_full = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD; // subtract is R-type only
          3'b001:  w_full = ALU_SLL;
          3'b010:  w_full = ALU_SLT;
          3'b011:  w_full = ALU_SLTU;
          3'b100:  w_full = ALU_XOR;
          3'b101:  w_full = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  w_full = ALU_OR;
          default: w_full = ALU_AND;
        endcase
      end
      default: w_full = ALU_ADD;
    endcase
  end

  assign o_alu_control = w_full[ALUCTRL_W-1:0];

  // A 3-bit ALU has no slt/sltu, and sra would alias onto srl.
  assign o_illegal = (ALUCTRL_W < 4) &&
                     ((i_funct3 == 3'b010) || (i_funct3 == 3'b011) ||
                      ((i_funct3 == 3'b101) && i_funct7b5));
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multicycle control FSM.
//   i_clk   - rising-edge clock
//   i_rst_n - synchronous active-low reset; also masks all write/request strobes
//   bus     - mc_ctrl_if master: instruction fields, ALU flags, mem_ready in;
//             datapath strobes and mux selects out
//   o_illegal_instr - sticky flag, set on entering TRAP
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W     = 4,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  mc_ctrl_if.master bus,
  output logic      o_illegal_instr
);
  state_t  r_state, w_next, w_ill_state;
  logic    r_illegal;
  logic    w_ready, w_taken, w_dec_illegal;
  logic    w_mem_req, w_mem_write, w_ir_write, w_pc_write, w_reg_write;
  alu_op_t w_alu_op;

  assign w_ready     = bus.mem_ready || (MEM_HANDSHAKE == 1'b0);
  assign w_ill_state = ILLEGAL_TRAP ? TRAP : FETCH;

  mc_alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7b5),
    .i_op5         (bus.op[5]),
    .o_alu_control (bus.alu_control),
    .o_illegal     (w_dec_illegal)
  );

  always_comb begin
    case (bus.funct3)
      3'b000:  w_taken = bus.zero;
      3'b001:  w_taken = ~bus.zero;
      3'b100:  w_taken = bus.negative ^ bus.overflow;
      3'b101:  w_taken = ~(bus.negative ^ bus.overflow);
      3'b110:  w_taken = ~bus.carry;   // carry=1 means no borrow: a >= b unsigned
      3'b111:  w_taken = bus.carry;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == TRAP) r_illegal <= 1'b1;
    end
  end

  // All illegal-instruction detection happens in DECODE so nothing has
  // been written when the trap / NOP decision is taken.
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = w_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: w_next = MEMADR;
          OP_RTYPE:  w_next = w_dec_illegal ? w_ill_state : EXECR;
          OP_ITYPE:  w_next = w_dec_illegal ? w_ill_state : EXECI;
          OP_BRANCH: w_next = (bus.funct3[2:1] == 2'b01) ? w_ill_state : BRANCH;
          OP_JAL:    w_next = JAL;
          OP_LUI:    w_next = LUI;
          default:   w_next = w_ill_state;
        endcase
      end
      MEMADR:   w_next = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = w_ready ? MEMWB : MEMREAD;
      MEMWB:    w_next = FETCH;
      MEMWRITE: w_next = w_ready ? FETCH : MEMWRITE;
      EXECR:    w_next = ALUWB;
      EXECI:    w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = FETCH;
      JAL:      w_next = ALUWB;
      LUI:      w_next = ALUWB;
      TRAP:     w_next = TRAP;
      default:  w_next = FETCH;
    endcase
  end

  always_comb begin
    w_mem_req      = 1'b0;
    w_mem_write    = 1'b0;
    w_ir_write     = 1'b0;
    w_pc_write     = 1'b0;
    w_reg_write    = 1'b0;
    w_alu_op       = ALUOP_ADD;
    bus.adr_src    = ADR_PC;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_WD;
    bus.imm_src    = IMM_I;
    case (r_state)
      FETCH: begin
        w_mem_req      = 1'b1;
        w_ir_write     = w_ready;
        w_pc_write     = w_ready;
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALU;
      end
      DECODE: begin
        bus.alu_src_a = SRCA_OLDPC;   // OldPC+imm -> ALUOut as branch/jal target
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = imm_of(bus.op);
      end
      MEMADR: begin
        bus.alu_src_a = SRCA_REG;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = imm_of(bus.op);
      end
      MEMREAD: begin
        w_mem_req   = 1'b1;
        bus.adr_src = ADR_ALUOUT;
      end
      MEMWB: begin
        bus.result_src = RES_DATA;
        w_reg_write    = 1'b1;
      end
      MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        bus.adr_src = ADR_ALUOUT;
      end
      EXECR: begin
        bus.alu_src_a = SRCA_REG;
        w_alu_op      = ALUOP_FUNCT;
      end
      EXECI: begin
        bus.alu_src_a = SRCA_REG;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = imm_of(bus.op);
        w_alu_op      = ALUOP_FUNCT;
      end
      ALUWB:  w_reg_write = 1'b1;
      BRANCH: begin
        bus.alu_src_a = SRCA_REG;
        w_alu_op      = ALUOP_SUB;
        w_pc_write    = w_taken;
      end
      JAL: begin
        bus.alu_src_a = SRCA_OLDPC;   // OldPC+4 -> ALUOut for the link write
        bus.alu_src_b = SRCB_FOUR;
        w_pc_write    = 1'b1;
      end
      LUI: begin
        bus.alu_src_a = SRCA_ZERO;
        bus.alu_src_b = SRCB_IMM;
        bus.imm_src   = imm_of(bus.op);
      end
      default: ;
    endcase
  end

  assign bus.mem_req   = w_mem_req   & i_rst_n;
  assign bus.mem_write = w_mem_write & i_rst_n;
  assign bus.ir_write  = w_ir_write  & i_rst_n;
  assign bus.pc_write  = w_pc_write  & i_rst_n;
  assign bus.reg_write = w_reg_write & i_rst_n;
  assign o_illegal_instr = r_illegal;
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle RV32I control decoder.
- An FSM sequences fetch, decode, execute, memory and writeback over several cycles, with an optional memory ready handshake.
- Adds bne/blt/bge/bltu/bgeu, slt/sltu/sra, jal, lui and illegal-instruction trapping.
- Drives the shared-memory multicycle datapath: PC, IR, OldPC, A, WriteData, ALUOut and Data registers.

Parameters:
- ALUCTRL_W, 4, alu_control width. Legal values are 3 and 4. At 3, slt/sltu/sra are illegal.
- MEM_HANDSHAKE, 1, wait-state handshake. At 1, memory states wait for mem_ready. At 0, mem_ready is ignored and treated as 1.
- ILLEGAL_TRAP, 1, illegal-op handling. At 1, an illegal op enters TRAP. At 0, the instruction is treated as a NOP and the FSM returns to FETCH.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero, negative, carry, overflow  in  1 each  ALU flags, valid combinationally in the BRANCH state
- mem_ready  in  1  memory access complete this cycle
- mem_req  out  1  memory access active
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  store strobe
- ir_write  out  1  IR and OldPC load enable
- pc_write  out  1  PC load enable
- reg_write  out  1  register file write enable
- result_src  out  2  result mux: 00=ALUOut, 01=Data, 10=ALU result
- alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=A, 11=zero
- alu_src_b  out  2  ALU B select: 00=WriteData, 01=imm, 10=constant 4
- imm_src  out  3  immediate format: 000=I, 001=S, 010=B, 011=J, 100=U
- alu_control  out  ALUCTRL_W  ALU operation
- illegal_instr  out  1  sticky illegal-instruction flag

Behaviour:
- Reset: a clock edge with rst_n=0 forces state=FETCH and clears illegal_instr. While rst_n=0, pc_write, ir_write, reg_write, mem_write and mem_req are forced to 0. Reset mid-instruction abandons the instruction with no writeback.
- Outputs are Moore (decoded from state), except:
  - alu_control and imm_src also depend on op/funct.
  - pc_write also depends on the flags in BRANCH.
  - Handshake-gated strobes depend on mem_ready.
- Any output not listed for a state is 0 in that state.
- Stall (X=ready) means mem_ready or MEM_HANDSHAKE==0.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - ir_write and pc_write follow X.
  - Go to DECODE on X, else hold.
- DECODE:
  - alu_src_a=01, alu_src_b=01, add; this latches the branch/jal target into ALUOut.
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0110111 → LUI
    - other → illegal handling
- MEMADR: alu_src_a=10, alu_src_b=01, add. Loads go to MEMREAD, stores to MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Go to MEMWB on X, else hold.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, adr_src=1, mem_write=1. Go to FETCH on X, else hold. mem_write stays high throughout the stall.
- EXECR: alu_src_a=10, alu_src_b=00, funct decode, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, funct decode, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, sub, result_src=00; pc_write=taken; then FETCH.
  - taken by funct3:
    - 000 beq: zero
    - 001 bne: ~zero
    - 100 blt: negative^overflow
    - 101 bge: ~(negative^overflow)
    - 110 bltu: ~carry
    - 111 bgeu: carry
  - funct3 010/011 is illegal.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, then ALUWB, which writes OldPC+4 to rd.
- LUI: alu_src_a=11, alu_src_b=01, add, then ALUWB.
- Illegal (undefined op, undefined funct, or an op that needs ALUCTRL_W=4 when ALUCTRL_W=3):
  - ILLEGAL_TRAP=1: illegal_instr set next edge; TRAP holds until reset with all strobes 0.
  - ILLEGAL_TRAP=0: go to FETCH with no writes.
- ALU decode:
  - alu_op=add: 0000. alu_op=sub: 0010.
  - funct decode by funct3:
    - 000: sub (0010) if op[5]&funct7b5, else add (0000)
    - 001: sll 0001
    - 010: slt 0011
    - 011: sltu 1011
    - 100: xor 0100
    - 101: sra (1101) if funct7b5, else srl (0101)
    - 110: or 0110
    - 111: and 0111
  - Output is the low ALUCTRL_W bits.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, TRAP (4-bit)
  - opcode constants
  - ALU encodings
  - mux select constants
- One combinational sub-module, mc_alu_decoder: inputs alu_op, funct3, funct7b5 and op[5]; outputs alu_control and an illegal bit.

Test Plan:
- Reset then add x3=x1+x2 (R-type, mem_ready=1) → FETCH→DECODE→EXECR→ALUWB→FETCH. reg_write pulses once in cycle 4 with alu_control=0000 during EXECR.
- lw with mem_ready low for 2 cycles in MEMREAD → mem_req/adr_src held 3 cycles, MEMWB one cycle later, 5+2 cycles total.
- bltu with carry=1 → pc_write=0. With carry=0 → pc_write=1. blt with negative=1, overflow=1 → pc_write=0.
- op=7'b1111111 with ILLEGAL_TRAP=1 → TRAP after DECODE, illegal_instr=1, no strobes until rst_n=0. With ILLEGAL_TRAP=0 → next state FETCH.
- ALUCTRL_W=3, sra (funct3=101, funct7b5=1) → illegal. ALUCTRL_W=4 → alu_control=1101.
- rst_n=0 at an edge during MEMWRITE stall → next state FETCH and mem_write=0 for the whole low period; fetch resumes after release.
